// File: rtl/zap_ram_rd_ctrl_if.sv
// Request/response and RAM-side bus of the fixed-latency RAM read controller.
// The slave modport is the controller's view; the master modport is the requester's and the RAM's view.
interface zap_ram_rd_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             i_req_valid;
    logic             o_req_ready;
    logic [AW-1:0]    i_req_addr;
    logic [AW-1:0]    o_mem_rd_addr;
    logic [WIDTH-1:0] i_mem_rd_data;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [WIDTH-1:0] o_rsp_data;
    logic             o_busy;

    modport slave (
        input  i_req_valid, i_req_addr, i_mem_rd_data, i_rsp_ready,
        output o_req_ready, o_mem_rd_addr, o_rsp_valid, o_rsp_data, o_busy
    );

    modport master (
        output i_req_valid, i_req_addr, i_mem_rd_data, i_rsp_ready,
        input  o_req_ready, o_mem_rd_addr, o_rsp_valid, o_rsp_data, o_busy
    );
endinterface

// File: rtl/zap_ram_rd_ctrl.sv
// Read initiator for fixed-latency pipelined RAMs. Reads are tracked in a valid shift register,
// and the returned data lands in a credit-protected FIFO, so the RAM never needs a stall input.
module zap_ram_rd_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int LATENCY   = 3,
    parameter int BUF_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    zap_ram_rd_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] BUF_LIM = (CW+1)'(BUF_DEPTH);

    logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [WIDTH-1:0]   mem_q [BUF_DEPTH];

    logic [CW-1:0]      inflight;
    logic [CW:0]        occupancy;
    logic [AW-1:0]      rd_addr;
    logic               issue, push, pop, rsp_valid, req_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++)
            inflight = inflight + {{(CW-1){1'b0}}, vld_pipe_q[i]};
    end

    // A pop in this cycle frees a slot, so a full FIFO with a draining consumer keeps accepting.
    assign rsp_valid = (fifo_cnt_q != '0);
    assign pop       = rsp_valid && bus.i_rsp_ready;
    assign push      = vld_pipe_q[LATENCY-1];
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_cnt_q};
    assign req_ready = i_reset_n && ((occupancy < BUF_LIM) || pop);
    assign issue     = bus.i_req_valid && req_ready;

    // The RAM reads every cycle; only issued reads are tracked in the valid pipe.
    assign rd_addr           = bus.i_req_addr;
    assign bus.o_mem_rd_addr = rd_addr;
    assign bus.o_req_ready   = req_ready;
    assign bus.o_rsp_valid   = rsp_valid;
    assign bus.o_rsp_data    = rsp_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.o_busy        = (inflight != '0) || rsp_valid;

    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = issue;
        for (int i = 1; i < LATENCY; i++)
            vld_pipe_d[i] = vld_pipe_q[i-1];

        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Clearing the valid pipe discards reads still in the RAM pipeline at reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_pipe_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem_q[wr_ptr_q] <= bus.i_mem_rd_data;
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(push && (fifo_cnt_q == BUF_LIM[CW-1:0])));
endmodule

// File: tb/tb_zap_ram_rd_ctrl.sv
// Bench for zap_ram_rd_ctrl: main instance LATENCY=3/BUF_DEPTH=4 plus LATENCY=1 and LATENCY=4
// instances sharing the same stimulus for the streaming check.
module tb_zap_ram_rd_ctrl;
    typedef struct {
        logic       req_valid;
        logic [4:0] addr;
        logic       rsp_ready;
        logic       exp_ready;
        logic       exp_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [31:0] ram [32];
    logic [31:0] rp3 [4];
    logic [31:0] rp1 [4];
    logic [31:0] rp4 [4];
    logic [31:0] sb [$];
    vec_t        vecs [17];
    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    int          max_occ = 0;

    always #5 clk = ~clk;

    zap_ram_rd_ctrl_if #(.WIDTH(32), .DEPTH(32)) bus3 ();
    zap_ram_rd_ctrl_if #(.WIDTH(32), .DEPTH(32)) bus1 ();
    zap_ram_rd_ctrl_if #(.WIDTH(32), .DEPTH(32)) bus4 ();

    zap_ram_rd_ctrl #(.WIDTH(32), .DEPTH(32), .LATENCY(3), .BUF_DEPTH(4))
        dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus3));
    zap_ram_rd_ctrl #(.WIDTH(32), .DEPTH(32), .LATENCY(1), .BUF_DEPTH(2))
        dut_l1 (.i_clk(clk), .i_reset_n(rst_n), .bus(bus1));
    zap_ram_rd_ctrl #(.WIDTH(32), .DEPTH(32), .LATENCY(4), .BUF_DEPTH(8))
        dut_l4 (.i_clk(clk), .i_reset_n(rst_n), .bus(bus4));

    assign bus3.i_req_valid = req_valid;
    assign bus3.i_req_addr  = req_addr;
    assign bus3.i_rsp_ready = rsp_ready;
    assign bus1.i_req_valid = req_valid;
    assign bus1.i_req_addr  = req_addr;
    assign bus1.i_rsp_ready = rsp_ready;
    assign bus4.i_req_valid = req_valid;
    assign bus4.i_req_addr  = req_addr;
    assign bus4.i_rsp_ready = rsp_ready;

    // RAM models: address sampled at the edge, data valid LATENCY edges later
    always @(posedge clk) begin
        rp3[0] <= ram[bus3.o_mem_rd_addr];
        rp1[0] <= ram[bus1.o_mem_rd_addr];
        rp4[0] <= ram[bus4.o_mem_rd_addr];
        for (int k = 1; k < 4; k++) begin
            rp3[k] <= rp3[k-1];
            rp1[k] <= rp1[k-1];
            rp4[k] <= rp4[k-1];
        end
    end
    assign bus3.i_mem_rd_data = rp3[2];
    assign bus1.i_mem_rd_data = rp1[0];
    assign bus4.i_mem_rd_data = rp4[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic vec_t mk(input logic v, input int a, input logic r,
                                input logic er, input logic ev);
        vec_t t;
        t.req_valid = v;
        t.addr      = 5'(a);
        t.rsp_ready = r;
        t.exp_ready = er;
        t.exp_valid = ev;
        return t;
    endfunction

    function automatic logic [32:0] stream_exp(input int c, input int lat);
        int k;
        k = c - lat - 1;
        if (k >= 0 && k < 8) return {1'b1, 32'(32'h100 + k)};
        return 33'h0;
    endfunction

    // Scoreboard on the main instance: expected data pushed at issue, popped at response handshake
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus3.o_rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_rsp actual=%0h required=none", bus3.o_rsp_data);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    chk("sb_data", 64'(bus3.o_rsp_data), 64'(e));
                    pops++;
                end
            end
            if (req_valid && bus3.o_req_ready) sb.push_back(ram[req_addr]);
            if (sb.size() > max_occ) max_occ = sb.size();
        end
    end

    task automatic single_read(input string nm);
        logic [33:0] e;
        req_valid = 1'b1;
        req_addr  = 5'd5;
        rsp_ready = 1'b1;
        settle();
        chk({nm, "_accept"}, 64'(bus3.o_req_ready), 64'(1));
        cyc();
        req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            settle();
            if (c < 4)       e = {2'b10, 32'h0};
            else if (c == 4) e = {2'b11, 32'hDEADBEEF};
            else             e = 34'h0;
            chk($sformatf("%s_c%0d", nm, c),
                64'({bus3.o_busy, bus3.o_rsp_valid, bus3.o_rsp_data}), 64'(e));
            cyc();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int issued, cycles, pops0;
        for (int i = 0; i < 32; i++) ram[i] = (i < 8) ? 32'(32'h100 + i) : $urandom;

        // backpressure table: columns req_valid, addr, rsp_ready, exp req_ready, exp rsp_valid
        vecs[0]  = mk(1, 0, 0, 1, 0);
        vecs[1]  = mk(1, 1, 0, 1, 0);
        vecs[2]  = mk(1, 2, 0, 1, 0);
        vecs[3]  = mk(1, 3, 0, 1, 0);
        vecs[4]  = mk(1, 4, 0, 0, 1);
        vecs[5]  = mk(1, 4, 0, 0, 1);
        vecs[6]  = mk(1, 4, 0, 0, 1);
        vecs[7]  = mk(1, 4, 0, 0, 1);
        vecs[8]  = mk(1, 4, 1, 1, 1);
        vecs[9]  = mk(1, 5, 1, 1, 1);
        vecs[10] = mk(1, 6, 1, 1, 1);
        vecs[11] = mk(1, 7, 1, 1, 1);
        vecs[12] = mk(0, 0, 1, 1, 1);
        vecs[13] = mk(0, 0, 1, 1, 1);
        vecs[14] = mk(0, 0, 1, 1, 1);
        vecs[15] = mk(0, 0, 1, 1, 1);
        vecs[16] = mk(0, 0, 1, 1, 0);

        // reset state
        #1;
        rst_n    = 1'b0;
        req_addr = 5'd7;
        #2;
        chk("rst_outputs", 64'({bus3.o_req_ready, bus3.o_rsp_valid, bus3.o_busy}), 64'(0));
        chk("rst_data", 64'(bus3.o_rsp_data), 64'(0));
        chk("rst_addr_follow", 64'(bus3.o_mem_rd_addr), 64'(7));
        cyc();
        cyc();
        rst_n = 1'b1;
        settle();
        chk("rel_ready", 64'({bus3.o_req_ready, bus1.o_req_ready, bus4.o_req_ready}), 64'(3'b111));

        // streaming on all three latencies
        for (int c = 0; c < 16; c++) begin
            req_valid = (c < 8);
            req_addr  = 5'(c);
            rsp_ready = 1'b1;
            settle();
            if (c < 8)
                chk($sformatf("stream_ready_c%0d", c),
                    64'({bus3.o_req_ready, bus1.o_req_ready, bus4.o_req_ready}), 64'(3'b111));
            chk($sformatf("stream_L3_c%0d", c), 64'({bus3.o_rsp_valid, bus3.o_rsp_data}), 64'(stream_exp(c, 3)));
            chk($sformatf("stream_L1_c%0d", c), 64'({bus1.o_rsp_valid, bus1.o_rsp_data}), 64'(stream_exp(c, 1)));
            chk($sformatf("stream_L4_c%0d", c), 64'({bus4.o_rsp_valid, bus4.o_rsp_data}), 64'(stream_exp(c, 4)));
            cyc();
        end
        req_valid = 1'b0;
        settle();
        chk("stream_idle", 64'({bus3.o_busy, bus1.o_busy, bus4.o_busy}), 64'(0));

        ram[5] = 32'hDEADBEEF;
        single_read("single");

        // backpressure
        for (int r = 0; r < 17; r++) begin
            req_valid = vecs[r].req_valid;
            req_addr  = vecs[r].addr;
            rsp_ready = vecs[r].rsp_ready;
            settle();
            chk($sformatf("bp_row%0d", r), 64'({bus3.o_req_ready, bus3.o_rsp_valid}),
                64'({vecs[r].exp_ready, vecs[r].exp_valid}));
            cyc();
        end
        req_valid = 1'b0;

        // toggling response ready, random addresses
        pops0    = pops;
        issued   = 0;
        cycles   = 0;
        req_addr = 5'($urandom_range(0, 31));
        while (issued < 32 && cycles < 400) begin
            req_valid = 1'b1;
            rsp_ready = cycles[0];
            settle();
            if (bus3.o_req_ready) begin
                issued++;
                cyc();
                req_addr = 5'($urandom_range(0, 31));
            end else begin
                cyc();
            end
            cycles++;
        end
        req_valid = 1'b0;
        while (sb.size() != 0 && cycles < 600) begin
            rsp_ready = cycles[0];
            cyc();
            cycles++;
        end
        chk("tog_issued", 64'(issued), 64'(32));
        chk("tog_pops", 64'(pops - pops0), 64'(32));
        chk("tog_sb_empty", 64'(sb.size()), 64'(0));
        chk("max_occupancy_le4", 64'(max_occ <= 4), 64'(1));

        // reset with 3 reads in flight and 1 buffered
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = 5'(i);
            settle();
            chk($sformatf("mid_issue%0d", i), 64'(bus3.o_req_ready), 64'(1));
            cyc();
        end
        req_valid = 1'b0;
        settle();
        chk("mid_pre_rst", 64'({bus3.o_rsp_valid, bus3.o_busy}), 64'(2'b11));
        rst_n = 1'b0;
        settle();
        chk("mid_rst_out", 64'({bus3.o_req_ready, bus3.o_rsp_valid, bus3.o_busy}), 64'(0));
        chk("mid_rst_data", 64'(bus3.o_rsp_data), 64'(0));
        sb.delete();
        cyc();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            chk($sformatf("post_rst_quiet_c%0d", c), 64'({bus3.o_rsp_valid, bus3.o_busy}), 64'(0));
            cyc();
        end
        single_read("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
